regfile_psr: RTL
================

# regfile_psr

Register file and processor status register (PSR) for the datapath. It supplies the ALU's A and B operands from two combinational read ports. It accepts the ALU result C on a synchronous write port and latches the ALU Flags into the PSR under a per-bit mask. The PSR carry bit is fed back to the ALU for add-with-carry operations.

## Interface
- WIDTH, 16: data width of each register and of the A/B/wr_data buses.
- NREGS, 16: number of general-purpose registers.
- ADDR_W, 4: register address width; must satisfy 2^ADDR_W >= NREGS.
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ra_addr  input  ADDR_W  read port A address.
- rb_addr  input  ADDR_W  read port B address.
- A  output  WIDTH  contents of register ra_addr (ALU operand A).
- B  output  WIDTH  contents of register rb_addr (ALU operand B).
- wr_en  input  1  write-enable for the register file.
- wr_addr  input  ADDR_W  destination register.
- wr_data  input  WIDTH  write data, normally the ALU result C.
- flags_en  input  1  latch ALU flags into the PSR.
- flags_in  input  5  ALU Flags: [0] N, [1] L, [2] F (overflow), [3] C (carry), [4] Z.
- flags_mask  input  5  per-bit update mask for flags_en; a 1 means update that bit.
- psr_load  input  1  software load of the whole PSR.
- psr_data  input  5  value for psr_load.
- psr  output  5  current PSR, same bit layout as flags_in.
- carry  output  1  psr[3], the carry-in to the ALU.

## Operation
- Storage:
  - NREGS x WIDTH registers.
  - 5-bit PSR.
- Reset:
  - While reset_n is low, every register and the PSR are forced to 0, asynchronously, regardless of clk or any enable.
  - During reset, A = B = 0, psr = 0 and carry = 0.
- Reads:
  - Purely combinational: A = regs[ra_addr], B = regs[rb_addr].
  - There is no write-through bypass. wr_data is derived combinationally from A/B through the ALU, so a bypass would form a combinational loop.
  - Out-of-range addresses (address >= NREGS) read as 0.
- Writes:
  - On the rising clk edge with wr_en = 1, regs[wr_addr] <= wr_data.
  - Writes to out-of-range addresses are discarded and no register changes.
  - wr_en = 0 leaves all registers unchanged.
- PSR update, at the rising clk edge:
  - psr_load = 1: psr <= psr_data. This has priority, and flags_en is ignored that cycle.
  - Otherwise, flags_en = 1: psr <= (psr & ~flags_mask) | (flags_in & flags_mask).
  - Otherwise: psr holds.
- Typical masks set by the decoder:
  - Arithmetic: 5'b11111.
  - Logical: 5'b10000, Z only.
  - CMP: 5'b00011, L and N only.
  - Shifts: 5'b00000.
- The register write and PSR update are independent and can occur in the same cycle.
- Reading and writing the same address in the same cycle is legal. The read returns the old value that cycle and the new value from the next cycle on.

## Timing
- Read latency: 0 cycles, combinational from the address and register state.
- Write latency: 1 cycle. Data presented with wr_en at edge k is visible on A/B immediately after edge k.
- PSR latency: 1 cycle. carry reflects the updated bit immediately after the edge, so a following ADDC/ADDCU in the next cycle sees it.
- Reset mid-operation:
  - Asserting reset_n low asynchronously aborts any write or PSR update pending at the next edge. Nothing is committed.
  - After deassertion, the first rising edge with reset_n high performs normal updates.
- reset_n deassertion is assumed synchronized externally to clk. The block adds no synchronizer.

## Test plan
- Reset: preload r3 = 16'h1234 and psr = 5'b11111, then pulse reset_n low between clock edges. Required: A (ra_addr = 3) = 0 and psr = 0 immediately, without waiting for a clock edge.
- Write/read: with wr_en = 1, wr_addr = 5, wr_data = 16'hBEEF, and ra_addr = rb_addr = 5 in the same cycle. Required: A = B = old value (0) before the edge and 16'hBEEF after it. With wr_en = 0 the next cycle and wr_data = 16'h0000, r5 stays 16'hBEEF.
- Masked flags: start from psr = 0, apply flags_en = 1, flags_in = 5'b11111, flags_mask = 5'b00011. Required: psr = 5'b00011. Then flags_in = 5'b01000 with mask 5'b11111 gives psr = 5'b01000 and carry = 1.
- Priority: psr_load = 1, psr_data = 5'b10100, together with flags_en = 1, flags_in = 5'b01011, mask = 5'b11111. Required: psr = 5'b10100 after the edge.
- Out-of-range (NREGS = 12): write 16'hAAAA to address 13. Required: reading addresses 13 and 1 returns 0 on both, and no in-range register changes.
- Full sweep: write r(i) = 16'h1000 + i for every i in 0..NREGS-1, then read all pairs on A and B. Required: every value matches with no aliasing.

Source files
------------

// File: rtl/regfile_psr.sv
// Register file with two combinational read ports, one synchronous write port,
// and a 5-bit PSR updated by masked ALU flags or a whole-register load.
module regfile_psr #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  A,
  output logic [WIDTH-1:0]  B,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              flags_en,
  input  logic [4:0]        flags_in,
  input  logic [4:0]        flags_mask,
  input  logic              psr_load,
  input  logic [4:0]        psr_data,
  output logic [4:0]        psr,
  output logic              carry
);

  localparam logic [ADDR_W:0] NREGS_W = NREGS[ADDR_W:0];

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [4:0]       psr_q, psr_d;
  logic             wr_ok, ra_ok, rb_ok;

  assign wr_ok = ({1'b0, wr_addr} < NREGS_W);
  assign ra_ok = ({1'b0, ra_addr} < NREGS_W);
  assign rb_ok = ({1'b0, rb_addr} < NREGS_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wr_en && wr_ok) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // No write bypass: wr_data comes from the ALU fed by A/B, so a bypass would loop.
  always_comb begin
    A = '0;
    B = '0;
    if (ra_ok) A = regs_q[ra_addr];
    if (rb_ok) B = regs_q[rb_addr];
  end

  always_comb begin
    psr_d = psr_q;
    if (psr_load)
      psr_d = psr_data;
    else if (flags_en)
      psr_d = (psr_q & ~flags_mask) | (flags_in & flags_mask);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) psr_q <= '0;
    else          psr_q <= psr_d;
  end

  assign psr   = psr_q;
  assign carry = psr_q[3];

endmodule
